// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the pipeline memory stage and a
// debug/loader port, one access per cycle. Define STARVE_GUARD_EN to enable the debug starvation guard.
module dmem_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          I_CLOCK,
    input  logic          I_LOCK,
    input  logic          I_PipeReq,
    input  logic          I_PipeWE,
    input  logic [AW-1:0] I_PipeAddr,
    input  logic [DW-1:0] I_PipeWData,
    output logic          O_PipeStall,
    output logic          O_PipeRValid,
    output logic [DW-1:0] O_PipeRData,
    input  logic          I_DbgReq,
    input  logic          I_DbgWE,
    input  logic [AW-1:0] I_DbgAddr,
    input  logic [DW-1:0] I_DbgWData,
    output logic          O_DbgGnt,
    output logic          O_DbgRValid,
    output logic [DW-1:0] O_DbgRData,
    output logic [AW-1:0] O_MemAddr,
    output logic          O_MemWE,
    output logic [DW-1:0] O_MemWData,
    input  logic [DW-1:0] I_MemRData
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    owner_t        owner_q, owner_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          dbg_gnt_q, dbg_gnt_d;
    logic          pipe_rvalid_q, pipe_rvalid_d;
    logic [DW-1:0] pipe_rdata_q, pipe_rdata_d;
    logic          dbg_rvalid_q, dbg_rvalid_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;

    logic force_dbg;
    logic pipe_win;
    logic dbg_win;
    logic rd_pending;

`ifdef STARVE_GUARD_EN
    logic [2:0] starve_q, starve_d;
    logic       starve_full;

    assign starve_full = (starve_q >= 3'(STARVE_LIMIT));

    // A loss is any edge where debug was requesting but the pipeline took the port.
    always_comb begin
        starve_d = starve_q;
        if (dbg_win) begin
            starve_d = '0;
        end else if (pipe_win && I_DbgReq && !starve_full) begin
            starve_d = starve_q + 3'd1;
        end
    end

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign force_dbg   = starve_full && I_DbgReq;
    assign O_PipeStall = force_dbg && I_PipeReq;
`else
    assign force_dbg   = 1'b0;
    assign O_PipeStall = 1'b0;
`endif

    // Debug may not win on the edge right after its own grant, so each debug access spans two cycles.
    always_comb begin
        pipe_win = I_PipeReq && !force_dbg;
        dbg_win  = !pipe_win && I_DbgReq && !dbg_gnt_q;
    end

    assign rd_pending = (owner_q != OWN_IDLE) && !mem_we_q;

    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        owner_d     = OWN_IDLE;
        dbg_gnt_d   = dbg_win;
        if (pipe_win) begin
            mem_addr_d  = I_PipeAddr;
            mem_we_d    = I_PipeWE;
            mem_wdata_d = I_PipeWData;
            owner_d     = OWN_PIPE;
        end else if (dbg_win) begin
            mem_addr_d  = I_DbgAddr;
            mem_we_d    = I_DbgWE;
            mem_wdata_d = I_DbgWData;
            owner_d     = OWN_DBG;
        end

        // Read data arrives one edge after issue and is steered by the owner tag of that issue.
        pipe_rvalid_d = rd_pending && (owner_q == OWN_PIPE);
        dbg_rvalid_d  = rd_pending && (owner_q == OWN_DBG);
        pipe_rdata_d  = pipe_rvalid_d ? I_MemRData : pipe_rdata_q;
        dbg_rdata_d   = dbg_rvalid_d ? I_MemRData : dbg_rdata_q;
    end

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            owner_q       <= OWN_IDLE;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= '0;
            dbg_gnt_q     <= 1'b0;
            pipe_rvalid_q <= 1'b0;
            pipe_rdata_q  <= '0;
            dbg_rvalid_q  <= 1'b0;
            dbg_rdata_q   <= '0;
        end else begin
            owner_q       <= owner_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_wdata_q   <= mem_wdata_d;
            dbg_gnt_q     <= dbg_gnt_d;
            pipe_rvalid_q <= pipe_rvalid_d;
            pipe_rdata_q  <= pipe_rdata_d;
            dbg_rvalid_q  <= dbg_rvalid_d;
            dbg_rdata_q   <= dbg_rdata_d;
        end
    end

    assign O_MemAddr    = mem_addr_q;
    assign O_MemWE      = mem_we_q;
    assign O_MemWData   = mem_wdata_q;
    assign O_DbgGnt     = dbg_gnt_q;
    assign O_PipeRValid = pipe_rvalid_q;
    assign O_PipeRData  = pipe_rdata_q;
    assign O_DbgRValid  = dbg_rvalid_q;
    assign O_DbgRData   = dbg_rdata_q;

endmodule
